// File: rtl/ex_muldiv_if.sv
// EX-stage handshake and result bus for the iterative multiply/divide unit.
// master = EX stage / pipeline control, slave = ex_muldiv.
interface ex_muldiv_if;
    logic        EX_start;
    logic [1:0]  EX_op;
    logic [31:0] EX_rdata1;
    logic [31:0] EX_rdata2;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        div_by_zero;

    modport master (
        output EX_start, EX_op, EX_rdata1, EX_rdata2, flush,
        input  stall, busy, done, HI, LO, div_by_zero
    );

    modport slave (
        input  EX_start, EX_op, EX_rdata1, EX_rdata2, flush,
        output stall, busy, done, HI, LO, div_by_zero
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU: 34-edge latency (2 for divide-by-zero), pipeline stalled while busy.
// Divider datapath present only when MULDIV_DIV_EN is defined; otherwise ops 1x return zeros in 2 edges.
module ex_muldiv (
    input  logic         clk,
    input  logic         rst,
    ex_muldiv_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;
    logic [1:0]  op;
    logic        sgn1;
    logic        sgn2;
    logic        dz;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        dz_q;

    logic        is_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] mul_sum;
    logic [63:0] fix_res;

    assign is_signed = ~bus.EX_op[0];
    assign a_mag     = (is_signed && bus.EX_rdata1[31]) ? -bus.EX_rdata1 : bus.EX_rdata1;
    assign b_mag     = (is_signed && bus.EX_rdata2[31]) ? -bus.EX_rdata2 : bus.EX_rdata2;

    // acc = {partial product, remaining multiplier bits}; add then shift right.
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);

`ifdef MULDIV_DIV_EN
    // acc = {partial remainder, dividend bits shifting into quotient}.
    logic [32:0] div_part;
    logic [32:0] div_diff;
    logic        div_ge;
    assign div_part = {acc[63:32], acc[31]};
    assign div_diff = div_part - {1'b0, opb};
    assign div_ge   = (div_part >= {1'b0, opb});
`endif

    always_comb begin
        fix_res = acc;
        if (!dz) begin
            case (op)
                2'b00: if (sgn1 ^ sgn2) fix_res = -acc;
`ifdef MULDIV_DIV_EN
                2'b10: begin
                    if (sgn1 ^ sgn2) fix_res[31:0]  = -acc[31:0];
                    if (sgn1)        fix_res[63:32] = -acc[63:32];
                end
`endif
                default: fix_res = acc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opb    <= 32'd0;
            op     <= 2'b00;
            sgn1   <= 1'b0;
            sgn2   <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (bus.EX_start) begin
                        op   <= bus.EX_op;
                        cnt  <= 5'd31;
                        sgn1 <= is_signed & bus.EX_rdata1[31];
                        sgn2 <= is_signed & bus.EX_rdata2[31];
                        dz   <= 1'b0;
                        if (!bus.EX_op[1]) begin
                            acc   <= {32'd0, b_mag};
                            opb   <= a_mag;
                            state <= MUL;
                        end else begin
`ifdef MULDIV_DIV_EN
                            if (bus.EX_rdata2 == 32'd0) begin
                                acc   <= {bus.EX_rdata1, 32'hFFFF_FFFF};
                                dz    <= 1'b1;
                                state <= FIX;
                            end else begin
                                acc   <= {32'd0, a_mag};
                                opb   <= b_mag;
                                state <= DIV;
                            end
`else
                            acc   <= 64'd0;
                            opb   <= 32'd0;
                            state <= FIX;
`endif
                        end
                    end
                    MUL: begin
                        acc <= {mul_sum, acc[31:1]};
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) state <= FIX;
                    end
`ifdef MULDIV_DIV_EN
                    DIV: begin
                        acc <= div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                                      : {div_part[31:0], acc[30:0], 1'b0};
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd0) state <= FIX;
                    end
`endif
                    FIX: begin
                        hi_q   <= fix_res[63:32];
                        lo_q   <= fix_res[31:0];
                        done_q <= 1'b1;
                        dz_q   <= dz;
                        state  <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Stall is gated by reset so the pipeline is released immediately on reset assertion.
    assign bus.stall = rst && ((state == MUL) || (state == DIV) || (state == FIX) ||
                               ((state == IDLE) && bus.EX_start));
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.HI          = hi_q;
    assign bus.LO          = lo_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed scoreboard bench for ex_muldiv; expectations from a behavioural arithmetic model.
module tb_ex_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    ex_muldiv_if bus();

    ex_muldiv u_dut (.clk(clk), .rst(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          compared = 0;
    int          mismatched = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa64, sb64, sp;
        logic signed [31:0] sa, sbv;
        e.dz = 1'b0;
        e.lat = 34;
        e.hi = 32'd0;
        e.lo = 32'd0;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        sa = a;
        sbv = b;
        case (op)
            2'b00: begin sp = sa64 * sb64; {e.hi, e.lo} = sp; end
            2'b01: {e.hi, e.lo} = {32'd0, a} * {32'd0, b};
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 2;
                end else if (op == 2'b11) begin
                    e.lo = a / b; e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'd0;
                end else begin
                    e.lo = sa / sbv; e.hi = sa % sbv;
                end
`else
                e.lat = 2;
`endif
            end
        endcase
        return e;
    endfunction

    // Starts at a negedge; returns at a negedge one cycle after the done pulse.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input bit poke);
        int edges;
        int stall_lo;
        exp_t e;
        bus.EX_op = op;
        bus.EX_rdata1 = a;
        bus.EX_rdata2 = b;
        bus.EX_start = 1'b1;
        sb.push_back(model(op, a, b));
        #1 check({tag, "_stall_req"}, bus.stall, 1);
        @(posedge clk);
        @(negedge clk);
        bus.EX_start = 1'b0;
        edges = 1;
        stall_lo = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            if (bus.stall !== 1'b1) stall_lo++;
            if (poke && edges == 5) begin
                bus.EX_start = 1'b1;
                bus.EX_op = ~op;
                bus.EX_rdata1 = ~a;
                bus.EX_rdata2 = 32'd0;
            end else begin
                bus.EX_start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check({tag, "_latency"}, edges, e.lat);
        check({tag, "_stall_busy"}, stall_lo, 0);
        check({tag, "_stall_done"}, bus.stall, 0);
        check({tag, "_busy_done"}, bus.busy, 1);
        check({tag, "_hi"}, bus.HI, e.hi);
        check({tag, "_lo"}, bus.LO, e.lo);
        check({tag, "_dz"}, bus.div_by_zero, e.dz);
        last_hi = e.hi;
        last_lo = e.lo;
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    initial begin
        int done_seen;
        logic [1:0] mid_op;
        bus.EX_start = 1'b1;
        bus.EX_op = 2'b01;
        bus.EX_rdata1 = 32'h1234_5678;
        bus.EX_rdata2 = 32'h9ABC_DEF0;
        bus.flush = 1'b0;

        #12;
        check("rst_outputs", {bus.stall, bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO}, 68'd0);

        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, "mult_neg3x5", 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin", 1'b0);
        run_op(2'b00, 32'h0001_2345, 32'hFFFF_8000, "mult_mixed", 1'b0);
        run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_0000, "multu_zero", 1'b0);
        run_op(2'b01, $urandom, $urandom, "multu_rand", 1'b1);
        run_op(2'b00, $urandom, $urandom, "mult_rand", 1'b0);

        repeat (3) @(negedge clk);
        check("hold_hi", bus.HI, last_hi);
        check("hold_lo", bus.LO, last_lo);

        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div_neg7by2", 1'b0);
        run_op(2'b11, 32'h0000_0064, 32'h0000_0007, "divu_100by7", 1'b0);
        run_op(2'b11, 32'h0000_0064, 32'h0000_0000, "divu_by0", 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, "div_7bym2", 1'b1);

        // Completed op, then a MULT aborted by flush on its 10th edge.
        run_op(2'b01, 32'h0000_1111, 32'h0000_0003, "pre_flush", 1'b0);
        bus.EX_op = 2'b00;
        bus.EX_rdata1 = 32'h7777_0000;
        bus.EX_rdata2 = 32'h0000_0009;
        bus.EX_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.EX_start = 1'b0;
        repeat (8) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_stall", bus.stall, 0);
        check("flush_hi", bus.HI, last_hi);
        check("flush_lo", bus.LO, last_lo);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("flush_no_done", done_seen, 0);

        // Flush beats a simultaneous start.
        bus.EX_start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.EX_start = 1'b0;
        bus.flush = 1'b0;
        check("flush_vs_start", bus.busy, 0);

        // Asynchronous reset mid-operation.
        run_op(2'b01, 32'h0BAD_F00D, 32'h0000_1234, "pre_rst", 1'b0);
`ifdef MULDIV_DIV_EN
        mid_op = 2'b10;
`else
        mid_op = 2'b01;
`endif
        bus.EX_op = mid_op;
        bus.EX_rdata1 = 32'h1234_5678;
        bus.EX_rdata2 = 32'h0000_0013;
        bus.EX_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.EX_start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst_outputs",
                 {bus.stall, bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO}, 68'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'h0001_0001, 32'hFFFF_0000, "post_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
